// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: op encodings, default widths
// and the result-mux / flag helpers used by the top.
package alu_pkg;

    localparam int ALU_WIDTH  = 16;
    localparam int ALU_DEST_W = 3;

    // Per-entry status bits carried alongside result and destination: z, n, flag_we.
    localparam int ALU_FLAG_BITS = 3;

    typedef enum logic [1:0] {
        ALU_OP_AND    = 2'b00,
        ALU_OP_OR     = 2'b01,
        ALU_OP_XOR    = 2'b10,
        ALU_OP_PASS_A = 2'b11
    } alu_op_e;

    // Default-width queue entry; the top re-declares it from its own parameters.
    typedef struct packed {
        logic [ALU_WIDTH-1:0]  result;
        logic [ALU_DEST_W-1:0] dest;
        logic                  z;
        logic                  n;
        logic                  flag_we;
    } alu_entry_t;

    localparam int ALU_ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready FIFO. Head and tail are explicit registers, so
// the head payload only moves when it is retired.
module skid_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Both at once only happens with exactly one entry: new data replaces the head.
            2'b11: head_d = in_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU output stage: logic-unit result select, Z/N flag compute, 2-deep result
// queue toward writeback and the architectural status flags.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int DEST_W = ALU_DEST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [WIDTH-1:0]  and_res,
    input  logic [WIDTH-1:0]  or_res,
    input  logic [WIDTH-1:0]  xor_res,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_z,
    output logic              out_n,
    output logic              stat_z,
    output logic              stat_n
);

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [DEST_W-1:0] dest;
        logic              z;
        logic              n;
        logic              flag_we;
    } entry_t;

    localparam int EW = WIDTH + DEST_W + ALU_FLAG_BITS;

    logic [WIDTH-1:0] result;
    entry_t           push_ent, head_ent;
    logic [EW-1:0]    head_bits;
    logic             stat_z_q, stat_z_d;
    logic             stat_n_q, stat_n_d;

    always_comb begin
        result = '0;
        unique case (alu_op_e'(in_op))
            ALU_OP_AND:    result = and_res;
            ALU_OP_OR:     result = or_res;
            ALU_OP_XOR:    result = xor_res;
            ALU_OP_PASS_A: result = a_in;
            default:       result = '0;
        endcase
    end

    always_comb begin
        push_ent.result  = result;
        push_ent.dest    = in_dest;
        push_ent.z       = (result == '0);
        push_ent.n       = result[WIDTH-1];
        push_ent.flag_we = in_flag_we;
    end

    skid_fifo2 #(.DW(EW)) u_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (push_ent),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_bits)
    );

    assign head_ent = entry_t'(head_bits);
    assign out_data = head_ent.result;
    assign out_dest = head_ent.dest;
    assign out_z    = head_ent.z;
    assign out_n    = head_ent.n;

    // Status flags commit at retire, not at accept, so they follow writeback order.
    always_comb begin
        stat_z_d = stat_z_q;
        stat_n_d = stat_n_q;
        if (out_valid && out_ready && head_ent.flag_we) begin
            stat_z_d = head_ent.z;
            stat_n_d = head_ent.n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_z_q <= 1'b0;
            stat_n_q <= 1'b0;
        end else begin
            stat_z_q <= stat_z_d;
            stat_n_q <= stat_n_d;
        end
    end

    assign stat_z = stat_z_q;
    assign stat_n = stat_n_q;

endmodule
